// File: rtl/br_pkg.sv
// Shared definitions for the sprite ROM arbiter: FSM state encoding and requester IDs.
package br_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] REQ_ROAD = 2'd0;
  localparam logic [1:0] REQ_CAR  = 2'd1;
  localparam logic [1:0] REQ_OBST = 2'd2;

endpackage

// File: rtl/br_prio_sel.sv
// Combinational winner selection: first asserted request scanning upward from ptr, wrapping.
// A constant ptr of zero gives plain lowest-index-wins priority.
module br_prio_sel #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            valid,
  output logic [1:0]      idx
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  int                off;
  int                sel;

  always_comb begin
    // Doubling the vector turns the rotate into a plain shift.
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NREQ-1:0];
    off     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off = k;
      end
    end
    sel = off + int'(ptr);
    if (sel >= NREQ) begin
      sel = sel - NREQ;
    end
    valid = |req;
    idx   = sel[1:0];
  end

endmodule

// File: rtl/sprite_rom_arb.sv
// Arbitrates NREQ sprite requesters onto one ROM read port (IDLE/READ/WAIT/DONE FSM).
// Define SPRITE_ROM_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module sprite_rom_arb #(
  parameter int NREQ    = 3,
  parameter int AW      = 16,
  parameter int DW      = 12,
  parameter int ROM_LAT = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]  ack,
  output logic [DW-1:0]    rdata,
  output logic             rom_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data,
  output logic             busy,
  output logic [1:0]       gnt_id
);
  import br_pkg::*;

  localparam logic [1:0] CNT_LAST = 2'(ROM_LAT - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rom_en_q, rom_en_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            busy_q, busy_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      cnt_q, cnt_d;

  logic [AW-1:0]   addr_arr [NREQ];
  logic            sel_valid;
  logic [1:0]      sel_idx;
  logic [1:0]      prio_ptr;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
    assign addr_arr[gi] = addr[gi*AW +: AW];
  end

`ifdef SPRITE_ROM_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  assign prio_ptr = ptr_q;
`else
  assign prio_ptr = REQ_ROAD;
`endif

  br_prio_sel #(.NREQ(NREQ)) u_prio_sel (
    .req   (req),
    .ptr   (prio_ptr),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rom_addr_d = rom_addr_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    rom_en_d   = 1'b0;
    ack_d      = '0;
`ifdef SPRITE_ROM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d    = ST_READ;
          gnt_d      = sel_idx;
          rom_addr_d = addr_arr[sel_idx];
          rom_en_d   = 1'b1;
          busy_d     = 1'b1;
`ifdef SPRITE_ROM_ARB_RR_EN
          ptr_d      = (sel_idx == 2'(NREQ - 1)) ? 2'd0 : sel_idx + 2'd1;
`endif
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // Last WAIT cycle is exactly when the ROM output is valid.
        if (cnt_q == CNT_LAST) begin
          rdata_d      = rom_data;
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      rdata_q    <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      gnt_q      <= '0;
      cnt_q      <= '0;
`ifdef SPRITE_ROM_ARB_RR_EN
      ptr_q      <= REQ_ROAD;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
`ifdef SPRITE_ROM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign gnt_id   = gnt_q;

endmodule
